datapath_core: RTL and testbench
================================

Name: datapath_core

Overview:
- Register-file, bus and ALU datapath that responds to the microcoded control unit's strobes: read_en, write_en, inc_en, clr_en and alu_op.
- Holds PC, AR, IR, AC, R and R1-R4, drives the single shared 16-bit bus, and addresses external synchronous instruction and data memories.
- Returns the opcode and the zero flag to the controller, closing the control/datapath loop.

Parameters:
- DW, 16, data/bus/register width.
- AW, 10, memory address width; PC, AR and the IR address field.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_en  in  4  bus source select code.
- write_en  in  16  per-destination load strobes.
- inc_en  in  16  per-register increment strobes.
- clr_en  in  16  per-register clear strobes.
- alu_op  in  3  ALU operation.
- instruction  out  6  IR[5:0], opcode to controller.
- z  out  16  16'd1 when AC==0, else 16'd0.
- im_addr  out  AW  PC.
- im_rdata  in  DW  instruction memory data, 1-cycle synchronous read.
- dm_addr  out  AW  AR.
- dm_wdata  out  DW  AC.
- dm_we  out  1  write_en[11].
- dm_rdata  in  DW  data memory data, 1-cycle synchronous read.
- bus_dbg  out  DW  current bus value, for the bench.

Behaviour:
- Reset (rst_n=0, async): PC, AR, IR, AC, R, R1-R4 = 0. Therefore instruction=0, z=16'd1, im_addr=0, dm_addr=0, dm_wdata=0, dm_we=0, bus_dbg=0. Reset mid-operation discards all state immediately; no pending writes survive.
- Bus mux is combinational, selected by read_en:
  - 0: 0
  - 1: PC (zero-extended)
  - 2: AR (zero-extended)
  - 4: {6'b0, IR[15:6]}, the address field
  - 5: AC
  - 6: R
  - 7-10: R1-R4
  - 12: dm_rdata
  - 13: im_rdata
  - 3, 11, 14, 15: 0
- write_en bit map, load on clk edge:
  - bit1: PC <= bus[AW-1:0]
  - bit2: AR <= bus[AW-1:0]
  - bit3: IR <= bus
  - bit4: AC <= bus
  - bit5: R <= bus
  - bits10/9/8/7: R1/R2/R3/R4 <= bus
  - bit11: dm_we
  - bit12: AC <= alu_result
  - bits 0, 6, 13-15: ignored
- inc_en bit map: bit1 PC+1 (wraps 2^AW-1 -> 0), bit4 AC+1 (wraps 16'hFFFF -> 0). Other bits ignored.
- clr_en bit map: bit1 PC <= 0, bit2 AR <= 0. Other bits ignored.
- Per-register priority: clr > write > inc. Example: write_en[1] and inc_en[1] both set (jump) -> PC <= bus, no increment.
- AC source priority: write_en[12] (ALU) > write_en[4] (bus) > inc_en[4].
- ALU is combinational on registered AC (A) and R (B); the result is registered only via write_en[12]. Widths are mod 2^16, with no flags other than z.
  - alu_op 1: A+B
  - alu_op 2: A-B
  - alu_op 3: (A*B)[15:0]
  - alu_op 4: A<<1 (LSB 0)
  - alu_op 0, 5-7: A, so write_en[12] leaves AC unchanged.
- Memories:
  - dm_addr=AR and im_addr=PC are continuous.
  - dm_rdata/im_rdata are valid one cycle after the address changes, which is why the controller holds the read for two states.
  - dm_we with dm_wdata=AC is sampled by the memory on the same edge.
- z and instruction are combinational from AC and IR, and stable for the whole cycle after the edge that updates them.
- Simultaneous events:
  - Multiple write_en bits load the same bus value into all selected registers.
  - A register read and written in the same cycle supplies its old value to the bus.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with AC=16'h1234 -> all registers 0 immediately, z=16'd1, dm_we=0. Release -> state holds.
- Fetch: PC=5, im_rdata=16'h0283, read_en=13, write_en=16'h0008 -> IR=16'h0283, instruction=6'd3. Then read_en=4 -> bus=16'h000A.
- Load/store: AR=7, dm_rdata=16'h00FF, read_en=12, write_en=16'h0010 -> AC=16'h00FF, z=0. Then write_en=16'h0800 -> dm_we=1, dm_addr=7, dm_wdata=16'h00FF.
- ALU with AC=16'h8001, R=16'h0003, write_en=16'h1000:
  - op1 -> AC=16'h8004
  - op2 from the original AC -> 16'h7FFE
  - op3 -> 16'h8003
  - op4 -> 16'h0002
  - op0 -> 16'h8001
- Priority/wrap:
  - PC=16'h3FF, inc_en=16'h0002 -> PC=0.
  - write_en[1]+inc_en[1] with bus=9 -> PC=9.
  - clr_en[1]+write_en[1] -> PC=0.
  - AC=16'hFFFF, inc_en=16'h0010 -> AC=0, z=16'd1.
- Register moves: AC=16'h0042, write_en=16'h0400 then read_en=7, write_en=16'h0020 -> R1=16'h0042, R=16'h0042. read_en=3 -> bus=0.

Source files
------------

// File: rtl/datapath_core.sv
// datapath_core: register file, shared bus mux and ALU driven by the
// microcoded controller's strobes. Returns opcode and zero flag.
module datapath_core #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    read_en,
    input  logic [15:0]   write_en,
    input  logic [15:0]   inc_en,
    input  logic [15:0]   clr_en,
    input  logic [2:0]    alu_op,
    output logic [5:0]    instruction,
    output logic [15:0]   z,
    output logic [AW-1:0] im_addr,
    input  logic [DW-1:0] im_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rdata,
    output logic [DW-1:0] bus_dbg
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);
    localparam logic [DW-1:0] AC_ONE = DW'(1);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ar;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_ac;
    logic [DW-1:0] r_r;
    logic [DW-1:0] r_r1;
    logic [DW-1:0] r_r2;
    logic [DW-1:0] r_r3;
    logic [DW-1:0] r_r4;
    logic [DW-1:0] w_bus;
    logic [DW-1:0] w_alu;
    logic          w_unused_strobes;

    // Shared bus source select; unassigned codes drive zero.
    always_comb begin
        w_bus = '0;
        case (read_en)
            4'd1:    w_bus = {{(DW-AW){1'b0}}, r_pc};
            4'd2:    w_bus = {{(DW-AW){1'b0}}, r_ar};
            4'd4:    w_bus = {{(DW-AW){1'b0}}, r_ir[DW-1:DW-AW]};
            4'd5:    w_bus = r_ac;
            4'd6:    w_bus = r_r;
            4'd7:    w_bus = r_r1;
            4'd8:    w_bus = r_r2;
            4'd9:    w_bus = r_r3;
            4'd10:   w_bus = r_r4;
            4'd12:   w_bus = dm_rdata;
            4'd13:   w_bus = im_rdata;
            default: w_bus = '0;
        endcase
    end

    // ALU on registered AC (A) and R (B); pass-through A for unused ops.
    always_comb begin
        w_alu = r_ac;
        case (alu_op)
            3'd1:    w_alu = r_ac + r_r;
            3'd2:    w_alu = r_ac - r_r;
            3'd3:    w_alu = r_ac * r_r;
            3'd4:    w_alu = {r_ac[DW-2:0], 1'b0};
            default: w_alu = r_ac;
        endcase
    end

    // PC: clear beats load beats increment, so a jump never also increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_pc <= '0;
        else if (clr_en[1])     r_pc <= '0;
        else if (write_en[1])   r_pc <= w_bus[AW-1:0];
        else if (inc_en[1])     r_pc <= r_pc + PC_ONE;
    end

    // AR: clear beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_ar <= '0;
        else if (clr_en[2])     r_ar <= '0;
        else if (write_en[2])   r_ar <= w_bus[AW-1:0];
    end

    // AC: ALU result beats bus load beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_ac <= '0;
        else if (write_en[12])  r_ac <= w_alu;
        else if (write_en[4])   r_ac <= w_bus;
        else if (inc_en[4])     r_ac <= r_ac + AC_ONE;
    end

    // Plain bus-loaded registers: IR, R and R1-R4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
            r_r  <= '0;
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
            r_r4 <= '0;
        end else begin
            if (write_en[3])  r_ir <= w_bus;
            if (write_en[5])  r_r  <= w_bus;
            if (write_en[10]) r_r1 <= w_bus;
            if (write_en[9])  r_r2 <= w_bus;
            if (write_en[8])  r_r3 <= w_bus;
            if (write_en[7])  r_r4 <= w_bus;
        end
    end

    // Memory write strobe is blocked during reset so nothing escapes.
    assign dm_we       = write_en[11] & rst_n;
    assign dm_addr     = r_ar;
    assign dm_wdata    = r_ac;
    assign im_addr     = r_pc;
    assign instruction = r_ir[5:0];
    assign z           = {15'd0, (r_ac == '0)};
    assign bus_dbg     = w_bus;

    assign w_unused_strobes = ^{write_en[0], write_en[6], write_en[15:13],
                                inc_en[15:5], inc_en[3:2], inc_en[0],
                                clr_en[15:3], clr_en[0]};

endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_datapath_core;

    logic        clk;
    logic        rst_n;
    logic [3:0]  read_en;
    logic [15:0] write_en;
    logic [15:0] inc_en;
    logic [15:0] clr_en;
    logic [2:0]  alu_op;
    logic [5:0]  instruction;
    logic [15:0] z;
    logic [9:0]  im_addr;
    logic [15:0] im_rdata;
    logic [9:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_we;
    logic [15:0] dm_rdata;
    logic [15:0] bus_dbg;

    datapath_core #(.DW(16), .AW(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_en     (read_en),
        .write_en    (write_en),
        .inc_en      (inc_en),
        .clr_en      (clr_en),
        .alu_op      (alu_op),
        .instruction (instruction),
        .z           (z),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_we       (dm_we),
        .dm_rdata    (dm_rdata),
        .bus_dbg     (bus_dbg)
    );

    localparam int S_BUS = 0, S_INSTR = 1, S_Z = 2, S_IMA = 3,
                   S_DMA = 4, S_DMW = 5, S_WE = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int sel, input logic [15:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Monitor: drain all pending expectations on each falling edge.
    exp_t        m_e;
    logic [15:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.sel)
                S_BUS:   m_act = bus_dbg;
                S_INSTR: m_act = {10'd0, instruction};
                S_Z:     m_act = z;
                S_IMA:   m_act = {6'd0, im_addr};
                S_DMA:   m_act = {6'd0, dm_addr};
                S_DMW:   m_act = dm_wdata;
                default: m_act = {15'd0, dm_we};
            endcase
            n_checks++;
            if (m_act !== m_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.exp);
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] rd, input logic [15:0] wr,
                        input logic [15:0] inc, input logic [15:0] clr,
                        input logic [2:0] op);
        read_en  = rd;
        write_en = wr;
        inc_en   = inc;
        clr_en   = clr;
        alu_op   = op;
        @(posedge clk);
        #1;
        read_en  = 4'd0;
        write_en = 16'd0;
        inc_en   = 16'd0;
        clr_en   = 16'd0;
        alu_op   = 3'd0;
    endtask

    task automatic peek_bus(input string name, input logic [3:0] rd, input logic [15:0] v);
        read_en = rd;
        expect_val(name, S_BUS, v);
        sync();
        read_en = 4'd0;
    endtask

    task automatic load_from_dm(input logic [15:0] v, input logic [15:0] wr);
        dm_rdata = v;
        step(4'd12, wr, 16'd0, 16'd0, 3'd0);
    endtask

    task automatic alu_case(input string name, input logic [2:0] op, input logic [15:0] v);
        load_from_dm(16'h8001, 16'h0010);
        step(4'd0, 16'h1000, 16'd0, 16'd0, op);
        expect_val(name, S_DMW, v);
        sync();
    endtask

    initial begin
        rst_n    = 1'b0;
        read_en  = 4'd0;
        write_en = 16'd0;
        inc_en   = 16'd0;
        clr_en   = 16'd0;
        alu_op   = 3'd0;
        im_rdata = 16'd0;
        dm_rdata = 16'd0;

        // Power-on reset state
        expect_val("rst_ac",    S_DMW,   16'h0000);
        expect_val("rst_z",     S_Z,     16'h0001);
        expect_val("rst_pc",    S_IMA,   16'h0000);
        expect_val("rst_ar",    S_DMA,   16'h0000);
        expect_val("rst_instr", S_INSTR, 16'h0000);
        expect_val("rst_we",    S_WE,    16'h0000);
        expect_val("rst_bus",   S_BUS,   16'h0000);
        sync();
        rst_n = 1'b1;

        // Reset asserted mid-cycle discards AC immediately
        load_from_dm(16'h1234, 16'h0010);
        expect_val("ac_loaded", S_DMW, 16'h1234);
        expect_val("ac_nz",     S_Z,   16'h0000);
        sync();
        step(4'd0, 16'd0, 16'd0, 16'd0, 3'd0);
        rst_n    = 1'b0;
        write_en = 16'h0800;
        expect_val("midrst_ac", S_DMW, 16'h0000);
        expect_val("midrst_z",  S_Z,   16'h0001);
        expect_val("midrst_we", S_WE,  16'h0000);
        sync();
        write_en = 16'd0;
        rst_n    = 1'b1;
        step(4'd0, 16'd0, 16'd0, 16'd0, 3'd0);
        expect_val("postrst_ac", S_DMW, 16'h0000);
        sync();

        // Fetch
        load_from_dm(16'h0005, 16'h0002);
        expect_val("pc_load", S_IMA, 16'h0005);
        peek_bus("bus_pc", 4'd1, 16'h0005);
        im_rdata = 16'h0283;
        step(4'd13, 16'h0008, 16'd0, 16'd0, 3'd0);
        expect_val("fetch_instr", S_INSTR, 16'h0003);
        sync();
        peek_bus("bus_addr_field", 4'd4, 16'h000A);

        // Load / store
        load_from_dm(16'h0007, 16'h0004);
        expect_val("ar_load", S_DMA, 16'h0007);
        peek_bus("bus_ar", 4'd2, 16'h0007);
        load_from_dm(16'h00FF, 16'h0010);
        expect_val("ld_ac", S_DMW, 16'h00FF);
        expect_val("ld_z",  S_Z,   16'h0000);
        sync();
        write_en = 16'h0800;
        expect_val("st_we",    S_WE,  16'h0001);
        expect_val("st_addr",  S_DMA, 16'h0007);
        expect_val("st_wdata", S_DMW, 16'h00FF);
        sync();
        write_en = 16'd0;

        // ALU
        load_from_dm(16'h0003, 16'h0020);
        alu_case("alu_add", 3'd1, 16'h8004);
        alu_case("alu_sub", 3'd2, 16'h7FFE);
        alu_case("alu_mul", 3'd3, 16'h8003);
        alu_case("alu_shl", 3'd4, 16'h0002);
        alu_case("alu_nop", 3'd0, 16'h8001);
        alu_case("alu_op7", 3'd7, 16'h8001);

        // AC priority: ALU result beats bus load (R=3, AC=5 -> 8)
        load_from_dm(16'h0005, 16'h0010);
        dm_rdata = 16'h0077;
        step(4'd12, 16'h1010, 16'h0010, 16'd0, 3'd1);
        expect_val("ac_alu_over_bus", S_DMW, 16'h0008);
        sync();
        step(4'd12, 16'h0010, 16'h0010, 16'd0, 3'd0);
        expect_val("ac_bus_over_inc", S_DMW, 16'h0077);
        sync();

        // PC wrap and priorities
        load_from_dm(16'h03FF, 16'h0002);
        step(4'd0, 16'd0, 16'h0002, 16'd0, 3'd0);
        expect_val("pc_wrap", S_IMA, 16'h0000);
        sync();
        step(4'd0, 16'd0, 16'h0002, 16'd0, 3'd0);
        expect_val("pc_inc", S_IMA, 16'h0001);
        sync();
        dm_rdata = 16'h0009;
        step(4'd12, 16'h0002, 16'h0002, 16'd0, 3'd0);
        expect_val("pc_jump", S_IMA, 16'h0009);
        sync();
        dm_rdata = 16'h0055;
        step(4'd12, 16'h0002, 16'h0002, 16'h0002, 3'd0);
        expect_val("pc_clr_wins", S_IMA, 16'h0000);
        sync();
        step(4'd12, 16'h0004, 16'd0, 16'h0004, 3'd0);
        expect_val("ar_clr_wins", S_DMA, 16'h0000);
        sync();

        // AC increment wrap
        load_from_dm(16'hFFFF, 16'h0010);
        step(4'd0, 16'd0, 16'h0010, 16'd0, 3'd0);
        expect_val("ac_wrap", S_DMW, 16'h0000);
        expect_val("ac_wrap_z", S_Z, 16'h0001);
        sync();

        // Register moves
        load_from_dm(16'h0042, 16'h0010);
        step(4'd5, 16'h0400, 16'd0, 16'd0, 3'd0);
        step(4'd7, 16'h0020, 16'd0, 16'd0, 3'd0);
        peek_bus("bus_r1", 4'd7, 16'h0042);
        peek_bus("bus_r",  4'd6, 16'h0042);
        peek_bus("bus_code3", 4'd3, 16'h0000);
        load_from_dm(16'h0011, 16'h0200);
        load_from_dm(16'h0022, 16'h0100);
        load_from_dm(16'h0033, 16'h0080);
        peek_bus("bus_r2", 4'd8,  16'h0011);
        peek_bus("bus_r3", 4'd9,  16'h0022);
        peek_bus("bus_r4", 4'd10, 16'h0033);
        peek_bus("bus_code11", 4'd11, 16'h0000);
        peek_bus("bus_code14", 4'd14, 16'h0000);

        // Multi-destination load and read-old-value in same cycle
        dm_rdata = 16'h00A5;
        step(4'd12, 16'h0030, 16'd0, 16'd0, 3'd0);
        peek_bus("multi_r", 4'd6, 16'h00A5);
        expect_val("multi_ac", S_DMW, 16'h00A5);
        sync();
        step(4'd7, 16'h0410, 16'd0, 16'd0, 3'd0);
        expect_val("old_r1_to_ac", S_DMW, 16'h0042);
        sync();
        peek_bus("r1_kept", 4'd7, 16'h0042);

        sync();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
